// File: rtl/mc_control_pkg.sv
// rtl/mc_control_pkg.sv - shared state, opcode and control-field encodings for the multi-cycle MIPS control unit
package mc_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_ADDIEX = 4'd8,
        S_ADDIWB = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_FAULT  = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Successor of DECODE for a given opcode; anything unsupported traps.
    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:   decode_next = S_MEMADR;
            OP_RTYPE:       decode_next = S_EXEC;
            OP_ADDI:        decode_next = S_ADDIEX;
            OP_BEQ, OP_BNE: decode_next = S_BRANCH;
            OP_J:           decode_next = S_JUMP;
            default:        decode_next = S_FAULT;
        endcase
    endfunction

endpackage

// File: rtl/mc_mem_timer.sv
// rtl/mc_mem_timer.sv - saturating wait-cycle counter flagging a stalled memory access
// Ports: clk, rst_n (sync active-low), clear (restart count), count_en (one more
// wait cycle), expire (count has reached LIMIT).
module mc_mem_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (count_en && (count != W'(LIMIT))) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == W'(LIMIT));

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS main control FSM (fetch/decode/execute/memory/write-back)
// Ports: clk, rst_n (sync active-low); opcode (sampled in DECODE); mem_ready
// (shared memory port handshake); datapath controls pc_write, ir_write, iord,
// mem_read, mem_write, memtoreg, regdst, regwrite, alusrca, branch_eq,
// branch_ne, alusrcb, aluop, pcsource; instr_done pulse; sticky fault;
// state_o debug view of the state.
// Optional: MC_CONTROL_TIMEOUT_EN adds a mem_ready timeout that traps to FAULT.
module mc_control
    import mc_control_pkg::*;
#(
    parameter int OP_WIDTH    = 6,
    parameter int ALUOP_WIDTH = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [OP_WIDTH-1:0]    opcode,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   ir_write,
    output logic                   iord,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   memtoreg,
    output logic                   regdst,
    output logic                   regwrite,
    output logic                   alusrca,
    output logic                   branch_eq,
    output logic                   branch_ne,
    output logic [1:0]             alusrcb,
    output logic [ALUOP_WIDTH-1:0] aluop,
    output logic [1:0]             pcsource,
    output logic                   instr_done,
    output logic                   fault,
    output logic [3:0]             state_o
);

    state_t              state;
    state_t              next_state;
    logic [OP_WIDTH-1:0] op_q;
    logic                expire;
    logic [1:0]          aluop_c;

`ifdef MC_CONTROL_TIMEOUT_EN
    logic in_mem_state;
    logic next_is_mem;
    logic tmr_clear;
    logic tmr_en;

    assign in_mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign next_is_mem  = (next_state == S_FETCH) || (next_state == S_MEMRD) ||
                          (next_state == S_MEMWR);
    // Restart only on entry, so a long wait in one state keeps accumulating.
    assign tmr_clear    = next_is_mem && (next_state != state);
    assign tmr_en       = in_mem_state && !mem_ready;

    mc_mem_timer #(
        .LIMIT(MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .count_en(tmr_en),
        .expire  (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)   next_state = S_DECODE;
                else if (expire) next_state = S_FAULT;
            end
            S_DECODE: next_state = decode_next(opcode);
            // DECODE only routes LW/SW here, so anything not SW is a load.
            S_MEMADR: next_state = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)   next_state = S_MEMWB;
                else if (expire) next_state = S_FAULT;
            end
            S_MEMWR: begin
                if (mem_ready)   next_state = S_FETCH;
                else if (expire) next_state = S_FAULT;
            end
            S_MEMWB:  next_state = S_FETCH;
            S_EXEC:   next_state = S_RWB;
            S_RWB:    next_state = S_FETCH;
            S_ADDIEX: next_state = S_ADDIWB;
            S_ADDIWB: next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            S_FAULT:  next_state = S_FAULT;
            default:  next_state = S_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
            op_q  <= '0;
        end else begin
            state <= next_state;
            if (state == S_DECODE) op_q <= opcode;
        end
    end

    // Outputs follow the current state; the FETCH/MEMWR strobes are qualified by
    // mem_ready, and everything is held low while reset is asserted.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        branch_eq  = 1'b0;
        branch_ne  = 1'b0;
        alusrcb    = SRCB_REGB;
        aluop_c    = ALUOP_ADD;
        pcsource   = PCSRC_ALU;
        instr_done = 1'b0;
        fault      = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    alusrcb  = SRCB_FOUR;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_DECODE: alusrcb = SRCB_IMM_SH;
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                end
                S_MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    memtoreg   = 1'b1;
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    iord       = 1'b1;
                    mem_write  = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    aluop_c = ALUOP_FUNCT;
                end
                S_RWB: begin
                    regdst     = 1'b1;
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                end
                S_ADDIWB: begin
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alusrca    = 1'b1;
                    aluop_c    = ALUOP_SUB;
                    pcsource   = PCSRC_ALUOUT;
                    instr_done = 1'b1;
                    branch_eq  = (op_q == OP_BEQ);
                    branch_ne  = (op_q == OP_BNE);
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pcsource   = PCSRC_JUMP;
                    instr_done = 1'b1;
                end
                S_FAULT: fault = 1'b1;
                default: fault = 1'b1;
            endcase
        end
    end

    assign aluop   = ALUOP_WIDTH'(aluop_c);
    assign state_o = rst_n ? state : S_FETCH;

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - self-checking bench for mc_control with randomized instruction streams
module tb_mc_control;
    import mc_control_pkg::*;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, iord, mem_read, mem_write, memtoreg, regdst, regwrite, alusrca;
    logic       branch_eq, branch_ne, instr_done, fault;
    logic [1:0] alusrcb, aluop, pcsource;
    logic [3:0] state_o;
    logic [18:0] all_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_control #(.OP_WIDTH(6), .ALUOP_WIDTH(2), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
        .alusrca(alusrca), .branch_eq(branch_eq), .branch_ne(branch_ne), .alusrcb(alusrcb),
        .aluop(aluop), .pcsource(pcsource), .instr_done(instr_done), .fault(fault),
        .state_o(state_o)
    );

    assign all_out = {pc_write, ir_write, iord, mem_read, mem_write, memtoreg, regdst, regwrite,
                      alusrca, branch_eq, branch_ne, alusrcb, aluop, pcsource, instr_done, fault};

    // Cycle cost with no memory stalls, straight from the instruction timing table.
    function automatic int base_cycles(input logic [5:0] op);
        case (op)
            OP_LW:          return 5;
            OP_SW:          return 4;
            OP_RTYPE:       return 4;
            OP_ADDI:        return 4;
            OP_BEQ, OP_BNE: return 3;
            default:        return 3;
        endcase
    endfunction

    function automatic logic [5:0] pick_op(input int k);
        case (k)
            0: return OP_LW;   1: return OP_SW;   2: return OP_RTYPE; 3: return OP_ADDI;
            4: return OP_BEQ;  5: return OP_BNE;  default: return OP_J;
        endcase
    endfunction

    // One-cycle reset pulse; the following cycle starts in FETCH.
    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        opcode = 6'($urandom);
        #1;
    endtask

    // Runs one instruction with fw fetch stalls and mw data stalls, then compares
    // per-instruction signal tallies against what the instruction must produce.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        int total, mstart, n_done, done_at, n_rd, n_wr, n_rw, n_pcw, n_irw, n_iord, n_beq, n_bne, n_bad;
        int e_rd, e_wr, e_rw, e_pcw, e_iord;
        logic is_mem;
        logic [3:0] first_state;
        logic [1:0] last_aluop, last_pcsrc;
        is_mem = (op == OP_LW) || (op == OP_SW);
        total  = base_cycles(op) + fw + (is_mem ? mw : 0);
        mstart = fw + 3;
        n_done = 0; done_at = -1; n_rd = 0; n_wr = 0; n_rw = 0; n_pcw = 0; n_irw = 0;
        n_iord = 0; n_beq = 0; n_bne = 0; n_bad = 0;
        first_state = '0; last_aluop = '0; last_pcsrc = '0;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            rst_n = 1'b1;
            if (c <= fw) mem_ready = (c == fw);
            else if (is_mem && c >= mstart && c <= mstart + mw) mem_ready = (c == mstart + mw);
            else mem_ready = 1'($urandom_range(0, 1));
            opcode = (c == fw + 1) ? op : 6'($urandom);
            #1;
            if (c == 0) first_state = state_o;
            if (instr_done) begin n_done++; done_at = c; end
            n_rd += int'(mem_read); n_wr += int'(mem_write); n_rw += int'(regwrite);
            n_pcw += int'(pc_write); n_irw += int'(ir_write); n_iord += int'(iord);
            n_beq += int'(branch_eq); n_bne += int'(branch_ne);
            if (mem_read && mem_write) n_bad++;
            if (regwrite && (mem_read || mem_write || iord)) n_bad++;
            if (fault) n_bad++;
            last_aluop = aluop; last_pcsrc = pcsource;
        end
        e_rd   = fw + 1 + ((op == OP_LW) ? mw + 1 : 0);
        e_wr   = (op == OP_SW) ? mw + 1 : 0;
        e_rw   = (op == OP_LW || op == OP_RTYPE || op == OP_ADDI) ? 1 : 0;
        e_pcw  = (op == OP_J) ? 2 : 1;
        e_iord = is_mem ? mw + 1 : 0;
        checks++; if (first_state !== S_FETCH) begin errors++; $display("FAIL start_state op=%b got %0d exp %0d", op, first_state, S_FETCH); end
        checks++; if (n_done !== 1 || done_at !== total - 1) begin errors++; $display("FAIL instr_done op=%b count %0d at %0d exp 1 at %0d", op, n_done, done_at, total - 1); end
        checks++; if (n_rd !== e_rd) begin errors++; $display("FAIL mem_read_cycles op=%b got %0d exp %0d", op, n_rd, e_rd); end
        checks++; if (n_wr !== e_wr) begin errors++; $display("FAIL mem_write_cycles op=%b got %0d exp %0d", op, n_wr, e_wr); end
        checks++; if (n_rw !== e_rw) begin errors++; $display("FAIL regwrite_cycles op=%b got %0d exp %0d", op, n_rw, e_rw); end
        checks++; if (n_pcw !== e_pcw || n_irw !== 1) begin errors++; $display("FAIL pc_ir_write op=%b got pcw %0d irw %0d exp %0d 1", op, n_pcw, n_irw, e_pcw); end
        checks++; if (n_iord !== e_iord) begin errors++; $display("FAIL iord_cycles op=%b got %0d exp %0d", op, n_iord, e_iord); end
        checks++; if (n_beq !== int'(op == OP_BEQ) || n_bne !== int'(op == OP_BNE)) begin errors++; $display("FAIL branch_sel op=%b got eq %0d ne %0d", op, n_beq, n_bne); end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL invariants op=%b violations %0d exp 0", op, n_bad); end
        if (op == OP_BEQ || op == OP_BNE) begin
            checks++; if (last_aluop !== 2'b01 || last_pcsrc !== 2'b01) begin errors++; $display("FAIL branch_alu op=%b got aluop %b pcsrc %b exp 01 01", op, last_aluop, last_pcsrc); end
        end
        if (op == OP_J) begin
            checks++; if (last_pcsrc !== 2'b10) begin errors++; $display("FAIL jump_pcsrc got %b exp 10", last_pcsrc); end
        end
    endtask

    task automatic test_reset();
        pulse_reset();
        checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", all_out); end
        checks++; if (state_o !== S_FETCH) begin errors++; $display("FAIL reset_state got %0d exp %0d", state_o, S_FETCH); end
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0; #1;
        checks++; if (state_o !== S_FETCH || mem_read !== 1'b1 || ir_write !== 1'b0) begin errors++; $display("FAIL post_reset_fetch got state %0d rd %b irw %b exp 0 1 0", state_o, mem_read, ir_write); end
        pulse_reset();
    endtask

    task automatic test_lw_sequence();
        logic [3:0] exp_seq [5];
        exp_seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rst_n = 1'b1; mem_ready = 1'b1;
            opcode = (c == 1) ? OP_LW : 6'($urandom);
            #1;
            checks++; if (state_o !== exp_seq[c]) begin errors++; $display("FAIL lw_state c=%0d got %0d exp %0d", c, state_o, exp_seq[c]); end
            checks++; if (instr_done !== (c == 4) || (c == 4 && (regwrite !== 1'b1 || memtoreg !== 1'b1))) begin errors++; $display("FAIL lw_done c=%0d got done %b rw %b mtr %b", c, instr_done, regwrite, memtoreg); end
        end
    endtask

    task automatic test_sw_wait();
        run_instr(OP_SW, 0, 3);
    endtask

    task automatic test_branches();
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_BNE, 1, 0);
        run_instr(OP_J, 0, 0);
    endtask

    task automatic test_fault();
        pulse_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            rst_n = 1'b1;
            mem_ready = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            opcode = (c == 1) ? 6'b111111 : 6'($urandom);
            #1;
            if (c >= 2) begin
                checks++; if (state_o !== S_FAULT || all_out !== 19'd1) begin errors++; $display("FAIL fault_hold c=%0d got state %0d outs %h exp %0d 1", c, state_o, all_out, S_FAULT); end
            end
        end
        pulse_reset();
        checks++; if (all_out !== '0) begin errors++; $display("FAIL fault_reset_outs got %h exp 0", all_out); end
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0; #1;
        checks++; if (state_o !== S_FETCH || mem_read !== 1'b1) begin errors++; $display("FAIL fault_recover got state %0d rd %b exp 0 1", state_o, mem_read); end
        pulse_reset();
    endtask

    task automatic test_reset_midinstr();
        int rw_seen;
        rw_seen = 0;
        pulse_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rst_n = (c != 3);
            mem_ready = (c <= 3);
            opcode = (c == 1) ? OP_LW : 6'($urandom);
            #1;
            rw_seen += int'(regwrite);
            if (c == 3) begin
                checks++; if (all_out !== '0) begin errors++; $display("FAIL midreset_outs got %h exp 0", all_out); end
            end
            if (c == 4) begin
                checks++; if (state_o !== S_FETCH || mem_read !== 1'b1) begin errors++; $display("FAIL midreset_fetch got state %0d rd %b exp 0 1", state_o, mem_read); end
            end
        end
        checks++; if (rw_seen !== 0) begin errors++; $display("FAIL midreset_regwrite got %0d exp 0", rw_seen); end
        pulse_reset();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            run_instr(pick_op(int'($urandom_range(0, 6))), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

`ifdef MC_CONTROL_TIMEOUT_EN
    task automatic test_timeout();
        for (int trial = 0; trial < 2; trial++) begin
            pulse_reset();
            for (int c = 0; c <= TMO + 1; c++) begin
                @(negedge clk);
                rst_n = 1'b1;
                mem_ready = (trial == 1 && c == TMO);
                opcode = OP_RTYPE;
                #1;
                if (c <= TMO) begin
                    checks++; if (state_o !== S_FETCH) begin errors++; $display("FAIL tmo_wait t=%0d c=%0d got %0d exp %0d", trial, c, state_o, S_FETCH); end
                end else begin
                    checks++; if (state_o !== (trial == 0 ? S_FAULT : S_DECODE)) begin errors++; $display("FAIL tmo_expire t=%0d got %0d", trial, state_o); end
                end
            end
        end
        pulse_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_lw_sequence();
        test_sw_wait();
        test_branches();
        test_fault();
        test_reset_midinstr();
`ifdef MC_CONTROL_TIMEOUT_EN
        test_timeout();
`endif
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
